// File: rtl/add2_arbiter.sv
// Round-robin arbiter sharing one halving adder ((in1+in2)>>1) among NREQ requesters.
// Define ADD2_ARB_ROUND_EN for round-half-up results through an extra pipeline stage (latency 2).
module add2_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int TAGW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_in1,
  input  logic [NREQ*WIDTH-1:0] req_in2,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_sum,
  output logic [TAGW-1:0]       res_tag
);

  logic [NREQ-1:0]  grant;
  logic [TAGW-1:0]  grant_idx;
  logic [TAGW-1:0]  cand;
  logic [TAGW-1:0]  ptr;
  logic [TAGW-1:0]  next_ptr;
  logic             found;
  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] half_hi;
  logic             lsb_adj;
  logic [WIDTH-1:0] half;

  // Scan from ptr upward, wrapping, and take the first valid requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    if (slot_free && !clear) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = TAGW'((int'(ptr) + k) % NREQ);
        if (!found && req_valid[cand]) begin
          found     = 1'b1;
          grant_idx = cand;
        end
      end
      if (found) grant[grant_idx] = 1'b1;
    end
  end

  assign req_ready = grant & {NREQ{rst_n}};
  assign accept    = found;
  assign next_ptr  = (grant_idx == TAGW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    op1 = '0;
    op2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        op1 = req_in1[i*WIDTH +: WIDTH];
        op2 = req_in2[i*WIDTH +: WIDTH];
      end
    end
  end

  // (a+b)>>>1 == (a>>>1)+(b>>>1)+(a0&b0); rounding up swaps the carry for (a0|b0).
  // Same result as the WIDTH+1 bit sum shifted right, and it cannot overflow.
  assign half_hi = {op1[WIDTH-1], op1[WIDTH-1:1]} + {op2[WIDTH-1], op2[WIDTH-1:1]};
`ifdef ADD2_ARB_ROUND_EN
  assign lsb_adj = op1[0] | op2[0];
`else
  assign lsb_adj = op1[0] & op2[0];
`endif
  assign half = half_hi + {{(WIDTH-1){1'b0}}, lsb_adj};

`ifdef ADD2_ARB_ROUND_EN
  logic             s1_valid;
  logic [WIDTH-1:0] s1_sum;
  logic [TAGW-1:0]  s1_tag;
  logic             out_free;

  assign out_free  = !res_valid || res_ready;
  assign slot_free = !s1_valid || out_free;

  // Two-stage pipeline: the stage register only loads when it is empty or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_tag    <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_tag   <= '0;
      ptr       <= '0;
    end else if (clear) begin
      s1_valid  <= 1'b0;
      res_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      if (out_free) begin
        res_valid <= s1_valid;
        if (s1_valid) begin
          res_sum <= s1_sum;
          res_tag <= s1_tag;
        end
      end
      if (accept) begin
        s1_valid <= 1'b1;
        s1_sum   <= half;
        s1_tag   <= grant_idx;
        ptr      <= next_ptr;
      end else if (out_free) begin
        s1_valid <= 1'b0;
      end
    end
  end
`else
  assign slot_free = !res_valid || res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_tag   <= '0;
      ptr       <= '0;
    end else if (clear) begin
      res_valid <= 1'b0;
      ptr       <= '0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_sum   <= half;
      res_tag   <= grant_idx;
      ptr       <= next_ptr;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end
`endif

endmodule
